// File: rtl/fod_pkg.sv
// Shared constants, FSM state type and ratio clamp for the FOD multi-modulus divider.
package fod_pkg;

    localparam int WI      = 6;   // MMD word width
    localparam int DTC_W   = 10;  // DTC word width
    localparam int MMD_MIN = 4;   // smallest legal divide ratio
    localparam int MMD_RST = 4;   // ratio held in the ratio register at reset

    // Divider control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } mmd_state_t;

    // Raise any ratio below the legal minimum to the minimum
    function automatic logic [WI-1:0] clamp_ratio(input logic [WI-1:0] word);
        if (word < WI'(MMD_MIN)) begin
            return WI'(MMD_MIN);
        end
        return word;
    endfunction

endpackage

// File: rtl/fod_mmd_cnt.sv
// Down-counter for one divided period, with reload and the duty comparator.
// The count runs n-1 .. 0 within a period; DIV_CLK is high while the
// remaining count sits in the upper floor(n/2) slots of the period.
module fod_mmd_cnt
    import fod_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,          // start a new period from n_in
    input  logic          run,           // decrement this cycle
    input  logic [WI-1:0] n_in,          // clamped ratio for the next period
    input  logic [WI-1:0] n_cur,         // ratio of the period in progress
    output logic          terminal,      // last cycle of the period
    output logic          div_clk_next   // divided clock level for the next cycle
);

    logic [WI-1:0] cnt;
    logic [WI-1:0] cnt_next;
    logic [WI-1:0] hi_thresh;

    // Next count: reload wins, otherwise decrement when running, else hold
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = n_in - WI'(1);
        end else if (run) begin
            cnt_next = cnt - WI'(1);
        end
    end

    // ceil(n/2): counts at or above this are the high half of the period
    assign hi_thresh    = n_cur - (n_cur >> 1);
    assign div_clk_next = load | (cnt_next >= hi_thresh);
    assign terminal     = (cnt == '0);

    // Count register, cleared to the reset ratio's start value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= WI'(MMD_RST - 1);
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/fod_mmd_core.sv
// Multi-modulus divider stage: divides CLK by the per-period MMD word,
// producing DIV_CLK / DIV_PULSE and re-timing the RT/DTC words so they
// change together with the divided edge they belong to.
// Words are sampled only at reload (the LOAD cycle or the terminal cycle of
// a running period); periods chain with no gap while EN stays high.
module fod_mmd_core
    import fod_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             EN,
    input  logic [WI-1:0]    MMD_DCW,
    input  logic             RT_DCW,
    input  logic [DTC_W-1:0] DTC_DCW,
    output logic             DIV_CLK,
    output logic             DIV_PULSE,
    output logic             RT_SEL,
    output logic [DTC_W-1:0] DTC_CODE,
    output logic             CLAMP_ERR,
    output logic [CNT_W-1:0] EDGE_CNT
);

    mmd_state_t    state;
    mmd_state_t    state_next;
    logic [WI-1:0] n_cur;
    logic [WI-1:0] n_in;
    logic          counting;
    logic          terminal;
    logic          reload;
    logic          run;
    logic          div_clk_next;

    assign n_in     = clamp_ratio(MMD_DCW);
    assign counting = (state == RUN) || (state == DRAIN);
    // Reload on LOAD, or back-to-back at the end of a period while enabled
    assign reload   = (state == LOAD) || (counting && terminal && EN);
    // Decrement inside a period; at a terminal stop the count rests at zero
    assign run      = counting && !terminal;

    fod_mmd_cnt u_cnt (
        .clk          (CLK),
        .rst          (ARST),
        .load         (reload),
        .run          (run),
        .n_in         (n_in),
        .n_cur        (n_cur),
        .terminal     (terminal),
        .div_clk_next (div_clk_next)
    );

    // Next-state: DRAIN only records that EN dropped; the period itself is
    // unaffected, and EN returning before the terminal cycle resumes RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (EN) state_next = LOAD;
            LOAD:        state_next = RUN;
            RUN, DRAIN: begin
                if (terminal) begin
                    state_next = EN ? RUN : IDLE;
                end else begin
                    state_next = EN ? RUN : DRAIN;
                end
            end
            default:     state_next = IDLE;
        endcase
    end

    // State, divided clock and pulse registers
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state     <= IDLE;
            DIV_CLK   <= 1'b0;
            DIV_PULSE <= 1'b0;
        end else begin
            state     <= state_next;
            DIV_CLK   <= (state != IDLE) && div_clk_next;
            DIV_PULSE <= reload;
        end
    end

    // Per-period word latches, clamp flag and edge counter, updated at reload
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            n_cur     <= WI'(MMD_RST);
            RT_SEL    <= 1'b0;
            DTC_CODE  <= '0;
            CLAMP_ERR <= 1'b0;
            EDGE_CNT  <= '0;
        end else if (reload) begin
            n_cur    <= n_in;
            RT_SEL   <= RT_DCW;
            DTC_CODE <= DTC_DCW;
            EDGE_CNT <= EDGE_CNT + CNT_W'(1);
            if (MMD_DCW < WI'(MMD_MIN)) begin
                CLAMP_ERR <= 1'b1;
            end
        end
    end

endmodule
